// File: rtl/clint_pkg.sv
// Shared constants, bus bundle types and the byte-merge helper for the core-local interruptor.
package clint_pkg;

    localparam logic [15:0] clint_msip        = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_lo = 16'h4000;
    localparam logic [15:0] clint_mtimecmp_hi = 16'h4004;
    localparam logic [15:0] clint_mtime_lo    = 16'hBFF8;
    localparam logic [15:0] clint_mtime_hi    = 16'hBFFC;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } clint_state_type;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } clint_in_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
    } clint_out_type;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Data-memory style valid/ready bus between the interconnect and the CLINT.
interface clint_if;
    logic        clint_valid;
    logic        clint_instr;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;

    modport master (
        output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready
    );

    modport slave (
        input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready
    );
endinterface

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime with per-half write override and the registered mtime >= mtimecmp compare.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] mtimecmp,
    input  logic        write_lo,
    input  logic        write_hi,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [63:0] mtime,
    output logic        timer_irpt
);

    logic [15:0] presc_r;
    logic [63:0] mtime_r;
    logic [63:0] mtime_s;
    logic        tick_s;
    logic        timer_irpt_r;

    assign tick_s     = (presc_r == 16'(PRESCALE - 1));
    assign mtime      = mtime_r;
    assign timer_irpt = timer_irpt_r;

    // Prescaler: free-running, never disturbed by software writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= 16'h0000;
        end else if (tick_s) begin
            presc_r <= 16'h0000;
        end else begin
            presc_r <= presc_r + 16'h0001;
        end
    end

    // A half-word write replaces that half and freezes the other one for this cycle.
    always_comb begin
        mtime_s = mtime_r;
        if (write_lo) begin
            mtime_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], wdata, wstrb)};
        end else if (write_hi) begin
            mtime_s = {merge_bytes(mtime_r[63:32], wdata, wstrb), mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_s = mtime_r + 64'd1;
        end else begin
            mtime_s = mtime_r;
        end
    end

    // mtime register and the registered compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_r      <= 64'd0;
            timer_irpt_r <= 1'b0;
        end else begin
            mtime_r      <= mtime_s;
            timer_irpt_r <= (mtime_r >= mtimecmp);
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped msip/mtimecmp/mtime with a two-state request/response FSM.
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic   clk,
    input  logic   rst,
    clint_if.slave bus,
    output logic   timer_irpt,
    output logic   soft_irpt
);

    clint_state_type state_r, state_s;
    clint_in_type    req_r, bus_in_s;
    clint_out_type   resp_s;
    logic [63:0]     mtimecmp_r;
    logic [63:0]     mtime_s;
    logic            msip_r;
    logic            soft_irpt_r;
    logic            latch_s;
    logic [31:0]     offset_s;
    logic [15:0]     word_s;
    logic            in_win_s;
    logic            is_write_s;
    logic            wr_msip_s, wr_cmp_lo_s, wr_cmp_hi_s, wr_time_lo_s, wr_time_hi_s;

    assign bus_in_s = '{valid: bus.clint_valid, instr: bus.clint_instr, addr: bus.clint_addr,
                        wdata: bus.clint_wdata, wstrb: bus.clint_wstrb};
    assign bus.clint_ready = resp_s.ready;
    assign bus.clint_rdata = resp_s.rdata;
    assign soft_irpt       = soft_irpt_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: accept in IDLE, respond for exactly one cycle, ignore valid while responding.
    always_comb begin
        state_s = state_r;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus_in_s.valid) begin
                    state_s = RESP;
                    latch_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Request capture at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r <= '0;
        end else if (latch_s) begin
            req_r <= bus_in_s;
        end else begin
            req_r <= req_r;
        end
    end

    // Address decode of the latched request; out-of-window offsets match nothing.
    always_comb begin
        offset_s     = req_r.addr - BASE_ADDR;
        word_s       = offset_s[15:0] & 16'hFFFC;
        in_win_s     = (offset_s[31:16] == 16'h0000);
        is_write_s   = (state_r == RESP) && req_r.valid && (req_r.wstrb != 4'h0) && !req_r.instr;
        wr_msip_s    = is_write_s && in_win_s && (word_s == clint_msip);
        wr_cmp_lo_s  = is_write_s && in_win_s && (word_s == clint_mtimecmp_lo);
        wr_cmp_hi_s  = is_write_s && in_win_s && (word_s == clint_mtimecmp_hi);
        wr_time_lo_s = is_write_s && in_win_s && (word_s == clint_mtime_lo);
        wr_time_hi_s = is_write_s && in_win_s && (word_s == clint_mtime_hi);
    end

    // Response: read data reflects registers as they stand during the RESP cycle.
    always_comb begin
        resp_s       = '0;
        resp_s.ready = (state_r == RESP);
        if ((state_r == RESP) && !is_write_s && in_win_s) begin
            case (word_s)
                clint_msip:        resp_s.rdata = {31'd0, msip_r};
                clint_mtimecmp_lo: resp_s.rdata = mtimecmp_r[31:0];
                clint_mtimecmp_hi: resp_s.rdata = mtimecmp_r[63:32];
                clint_mtime_lo:    resp_s.rdata = mtime_s[31:0];
                clint_mtime_hi:    resp_s.rdata = mtime_s[63:32];
                default:           resp_s.rdata = 32'd0;
            endcase
        end else begin
            resp_s.rdata = 32'd0;
        end
    end

    // Software-visible registers and the soft interrupt level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r      <= 1'b0;
            soft_irpt_r <= 1'b0;
        end else begin
            if (wr_cmp_lo_s) begin
                mtimecmp_r[31:0] <= merge_bytes(mtimecmp_r[31:0], req_r.wdata, req_r.wstrb);
            end else if (wr_cmp_hi_s) begin
                mtimecmp_r[63:32] <= merge_bytes(mtimecmp_r[63:32], req_r.wdata, req_r.wstrb);
            end else begin
                mtimecmp_r <= mtimecmp_r;
            end
            if (wr_msip_s && req_r.wstrb[0]) begin
                msip_r <= req_r.wdata[0];
            end else begin
                msip_r <= msip_r;
            end
            soft_irpt_r <= msip_r;
        end
    end

    clint_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .mtimecmp   (mtimecmp_r),
        .write_lo   (wr_time_lo_s),
        .write_hi   (wr_time_hi_s),
        .wdata      (req_r.wdata),
        .wstrb      (req_r.wstrb),
        .mtime      (mtime_s),
        .timer_irpt (timer_irpt)
    );

endmodule
